// File: rtl/async_fifo.sv
// async_fifo: Gray-pointer FIFO of 2^DATA_DEPTH words, single clock w_clk.
// Pointers cross between the write and read sides through 2-flop
// synchronizers, so the flags assert at once and deassert 2 cycles late.
// Ports:
//   w_clk       sole clock, rising edge
//   w_rstn      asynchronous active-low reset
//   w_en        write request, accepted when fifo_full=0
//   write_data  word written on an accepted write
//   r_en        read request, accepted when fifo_empty=0
//   read_data   registered read data, holds when no read is accepted
//   fifo_full   no write can be accepted (combinational from registers)
//   fifo_empty  no read can be accepted (combinational from registers)
module async_fifo #(
  parameter int unsigned DATA_DEPTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  w_clk,
  input  logic                  w_rstn,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  fifo_full,
  output logic                  fifo_empty
);

  localparam int unsigned PTR_W     = DATA_DEPTH + 1;
  localparam int unsigned MEM_WORDS = 1 << DATA_DEPTH;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic [PTR_W-1:0] r_wptr, r_wgray;
  logic [PTR_W-1:0] r_rptr, r_rgray;
  logic [PTR_W-1:0] r_wq1, r_wq2;   // write Gray pointer seen by read side
  logic [PTR_W-1:0] r_rq1, r_rq2;   // read Gray pointer seen by write side

  logic             w_wr_acc, w_rd_acc;
  logic [PTR_W-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [PTR_W-1:0] w_wgray_nxt, w_rgray_nxt;

  assign w_wr_acc    = w_en & ~fifo_full;
  assign w_rd_acc    = r_en & ~fifo_empty;
  assign w_wptr_nxt  = r_wptr + PTR_W'(1);
  assign w_rptr_nxt  = r_rptr + PTR_W'(1);
  assign w_wgray_nxt = w_wptr_nxt ^ (w_wptr_nxt >> 1);
  assign w_rgray_nxt = w_rptr_nxt ^ (w_rptr_nxt >> 1);

  // Full when the write side is exactly one lap ahead: top two Gray bits
  // inverted, the rest equal.
  assign fifo_full  = (r_wgray == {~r_rq2[PTR_W-1 -: 2], r_rq2[PTR_W-3:0]});
  assign fifo_empty = (r_rgray == r_wq2);

  // Storage write; the array is intentionally not reset.
  always_ff @(posedge w_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[DATA_DEPTH-1:0]] <= write_data;
    end
  end

  // Write pointer, binary and registered Gray copy.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_wptr  <= '0;
      r_wgray <= '0;
    end else if (w_wr_acc) begin
      r_wptr  <= w_wptr_nxt;
      r_wgray <= w_wgray_nxt;
    end
  end

  // Read pointer and registered read data.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_rptr    <= '0;
      r_rgray   <= '0;
      read_data <= '0;
    end else if (w_rd_acc) begin
      r_rptr    <= w_rptr_nxt;
      r_rgray   <= w_rgray_nxt;
      read_data <= r_mem[r_rptr[DATA_DEPTH-1:0]];
    end
  end

  // Two-stage synchronizers in both directions.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_wq1 <= r_wgray;
      r_wq2 <= r_wq1;
      r_rq1 <= r_rgray;
      r_rq2 <= r_rq1;
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo (default 1024 x 32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_async_fifo;

  logic        w_clk = 1'b0;
  logic        w_rstn = 1'b0;
  logic        w_en = 1'b0;
  logic [31:0] write_data = '0;
  logic        r_en = 1'b0;
  logic [31:0] read_data;
  logic        fifo_full;
  logic        fifo_empty;

  int checks = 0;
  int failures = 0;

  async_fifo #(.DATA_DEPTH(10), .DATA_WIDTH(32)) dut (
    .w_clk      (w_clk),
    .w_rstn     (w_rstn),
    .w_en       (w_en),
    .write_data (write_data),
    .r_en       (r_en),
    .read_data  (read_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  always #5 w_clk = ~w_clk;

  // One rising edge, then settle at the falling edge.
  task automatic step();
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic test_reset();
    w_rstn = 1'b0;
    repeat (5) step();
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: empty=%b full=%b rd=%h, want 1 0 0", fifo_empty, fifo_full, read_data);
    end
    // Read attempt right after release must not do anything.
    w_rstn = 1'b1;
    r_en   = 1'b1;
    step();
    r_en = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_read_empty: empty=%b full=%b rd=%h, want 1 0 0", fifo_empty, fifo_full, read_data);
    end
  endtask

  task automatic test_fill();
    logic exp_full, exp_empty;
    r_en = 1'b0;
    for (int i = 0; i < 1124; i++) begin
      w_en = 1'b1;
      write_data = 32'(i);
      step();
      exp_full  = (i >= 1023);
      exp_empty = (i < 2);
      checks++;
      if (fifo_full !== exp_full || fifo_empty !== exp_empty) begin
        failures++;
        $display("FAIL fill_flags[%0d]: full=%b empty=%b, want %b %b", i, fifo_full, fifo_empty, exp_full, exp_empty);
      end
    end
    w_en = 1'b0;
  endtask

  task automatic test_drain();
    logic [31:0] exp_rd;
    logic        exp_full, exp_empty;
    r_en = 1'b1;
    for (int j = 0; j < 1100; j++) begin
      step();
      exp_rd    = (j < 1024) ? 32'(j) : 32'd1023;
      exp_full  = (j < 2);
      exp_empty = (j >= 1023);
      checks++;
      if (read_data !== exp_rd || fifo_full !== exp_full || fifo_empty !== exp_empty) begin
        failures++;
        $display("FAIL drain[%0d]: rd=%0d full=%b empty=%b, want %0d %b %b", j, read_data, fifo_full, fifo_empty, exp_rd, exp_full, exp_empty);
      end
    end
  endtask

  task automatic test_latency();
    // r_en still held high from the drain; FIFO is empty, read_data=1023.
    r_en = 1'b1;
    w_en = 1'b1;
    write_data = 32'hA5A5A5A5;
    step();                            // edge k
    w_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (read_data !== 32'd1023 || fifo_empty !== (c < 3)) begin
        failures++;
        $display("FAIL latency_wait[%0d]: rd=%h empty=%b, want %h %b", c, read_data, fifo_empty, 32'd1023, (c < 3));
      end
      step();                          // edges k+1, k+2, k+3
    end
    checks++;
    if (read_data !== 32'hA5A5A5A5 || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL latency_read: rd=%h empty=%b, want a5a5a5a5 1", read_data, fifo_empty);
    end
    r_en = 1'b0;
  endtask

  task automatic test_concurrent();
    logic [31:0] exp_q[$];
    logic        pre_empty;
    logic        saw_full;
    int          nread;
    int          bad;
    logic [31:0] exp_v;
    saw_full = 1'b0;
    nread = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) exp_q.push_back(32'(i));
    for (int i = 0; i < 924; i++) exp_q.push_back(32'(i));
    // 1024 write cycles followed by a bounded drain.
    for (int c = 0; c < 3000; c++) begin
      w_en = (c < 1024);
      write_data = (c < 100) ? 32'(c) : 32'(c - 100);
      r_en = (c >= 100);
      pre_empty = fifo_empty;
      if (fifo_full) saw_full = 1'b1;
      step();
      if (r_en && !pre_empty) begin
        exp_v = (nread < exp_q.size()) ? exp_q[nread] : 32'hDEADBEEF;
        if (read_data !== exp_v && bad < 5) begin
          $display("FAIL concurrent_data[%0d]: rd=%0d, want %0d", nread, read_data, exp_v);
        end
        if (read_data !== exp_v) bad++;
        nread++;
      end
      if (c >= 1024 && fifo_empty && nread >= 1024) break;
    end
    w_en = 1'b0;
    r_en = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL concurrent_stream: %0d wrong words, want 0", bad);
    end
    checks++;
    if (nread != 1024) begin
      failures++;
      $display("FAIL concurrent_count: reads=%0d, want 1024", nread);
    end
    checks++;
    if (saw_full !== 1'b0) begin
      failures++;
      $display("FAIL concurrent_full: full seen=%b, want 0", saw_full);
    end
  endtask

  task automatic test_reset_mid();
    r_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      w_en = 1'b1;
      write_data = 32'(1000 + i);
      step();
    end
    w_en = 1'b0;
    step();
    step();
    checks++;
    if (fifo_empty !== 1'b0 || read_data === 32'h0) begin
      failures++;
      $display("FAIL premid_state: empty=%b rd=%h, want 0 and nonzero", fifo_empty, read_data);
    end
    w_rstn = 1'b0;
    #1;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: empty=%b full=%b rd=%h, want 1 0 0", fifo_empty, fifo_full, read_data);
    end
    @(negedge w_clk);
    w_rstn = 1'b1;
    w_en = 1'b1;
    write_data = 32'h1234;
    step();
    w_en = 1'b0;
    step();
    step();
    checks++;
    if (fifo_empty !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_avail: empty=%b rd=%h, want 0 0", fifo_empty, read_data);
    end
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    checks++;
    if (read_data !== 32'h1234 || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_read: rd=%h empty=%b, want 1234 1", read_data, fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
